eth_rx_udma_packer: RTL

ETH_RX_UDMA_PACKER -- requirements
Module: eth_rx_udma_packer

---
 rtl/eth_rx_pkg.sv | 29 ++
 rtl/eth_rx_word_fifo.sv | 64 ++++++
 rtl/eth_rx_udma_packer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet RX to uDMA byte packer.
//   rx_state_e   : capture FSM states
//   lane_t       : byte lane index inside a 32-bit word
//   insert_byte  : place a byte into its little-endian lane of a word
package eth_rx_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_RECV     = 2'd1,
    ST_DROP     = 2'd2
  } rx_state_e;

  // OR a byte into lane 'lane' (lane 0 = bits [7:0]); other lanes untouched.
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] word,
    input lane_t             lane,
    input logic [BYTE_W-1:0] b
  );
    return word | (WORD_W'(b) << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/eth_rx_word_fifo.sv
// First-word-fall-through word FIFO between the packer and the uDMA channel.
//   clk_i, rstn_i : clock, synchronous active-low reset (clears pointers/count)
//   push_i/data_i : write request and word; ignored when full unless popping
//   pop_i         : read request; ignored when empty
//   data_o        : head word (zero when empty)
//   empty_o/full_o: occupancy flags derived from the registered count
module eth_rx_word_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o = empty_o ? '0 : mem_q[rd_q];

  // Storage array: no reset needed, contents gated by the count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/eth_rx_udma_packer.sv
// Packs received Ethernet bytes into little-endian 32-bit words for a uDMA
// RX channel and reports per-frame length and error status.
//   clk_i, rstn_i     : clock, synchronous active-low reset
//   en_i              : capture enable, only looked at on a frame's first byte
//   rx_axis_*_i       : byte stream from MAC RX FIFO (always accepted)
//   data_o/valid_o    : packed word towards uDMA, handshake with ready_i
//   frame_done_o      : one-cycle pulse after the last byte of a captured frame
//   frame_len_o       : byte count of last captured frame (saturating)
//   frame_err_o       : tuser / word overflow / length saturation of last frame
//   overflow_o        : pulses in the cycle a word is dropped on a full FIFO
module eth_rx_udma_packer
  import eth_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic [BYTE_W-1:0]    rx_axis_tdata_i,
  input  logic                 rx_axis_tvalid_i,
  input  logic                 rx_axis_tlast_i,
  input  logic                 rx_axis_tuser_i,
  output logic [WORD_W-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_done_o,
  output logic [LEN_WIDTH-1:0] frame_len_o,
  output logic                 frame_err_o,
  output logic                 overflow_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  rx_state_e            state_q, state_d;
  lane_t                lane_q, lane_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [LEN_WIDTH-1:0] flen_q, flen_d;
  logic                 ferr_q, ferr_d;

  logic                 cap;
  logic                 sof;
  lane_t                lane_cur;
  logic [WORD_W-1:0]    word_base;
  logic [WORD_W-1:0]    word_new;
  logic [LEN_WIDTH-1:0] len_base;
  logic [LEN_WIDTH-1:0] len_new;
  logic                 err_base;
  logic                 err_new;
  logic                 sat_hit;
  logic                 push_c;
  logic [WORD_W-1:0]    push_word_c;
  logic                 ovf_c;
  logic                 pop_c;
  logic                 fifo_empty;
  logic                 fifo_full;

  assign valid_o      = !fifo_empty;
  assign pop_c        = valid_o && ready_i;
  assign overflow_o   = ovf_c;
  assign frame_done_o = done_q;
  assign frame_len_o  = flen_q;
  assign frame_err_o  = ferr_q;

  // Next-state: capture decision, lane packing, length/error tracking.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_d      = word_q;
    len_d       = len_q;
    err_d       = err_q;
    done_d      = 1'b0;
    flen_d      = flen_q;
    ferr_d      = ferr_q;
    cap         = 1'b0;
    sof         = 1'b0;
    lane_cur    = lane_q;
    word_base   = word_q;
    word_new    = word_q;
    len_base    = len_q;
    len_new     = len_q;
    err_base    = err_q;
    err_new     = err_q;
    sat_hit     = 1'b0;
    push_c      = 1'b0;
    push_word_c = '0;
    ovf_c       = 1'b0;

    if (rx_axis_tvalid_i) begin
      unique case (state_q)
        ST_WAIT_SOF: begin
          if (en_i) begin
            cap = 1'b1;
            sof = 1'b1;
          end else if (!rx_axis_tlast_i) begin
            state_d = ST_DROP;
          end
        end
        ST_RECV: cap = 1'b1;
        ST_DROP: begin
          if (rx_axis_tlast_i) begin
            state_d = ST_WAIT_SOF;
          end
        end
        default: state_d = ST_WAIT_SOF;
      endcase
    end

    if (cap) begin
      // First byte of a frame restarts lane, word and counters.
      lane_cur  = sof ? '0 : lane_q;
      word_base = sof ? '0 : word_q;
      len_base  = sof ? '0 : len_q;
      err_base  = sof ? 1'b0 : err_q;

      word_new = insert_byte(word_base, lane_cur, rx_axis_tdata_i);
      sat_hit  = (len_base == LEN_MAX);
      len_new  = sat_hit ? len_base : len_base + LEN_WIDTH'(1);

      push_c      = (lane_cur == lane_t'(BYTES_PER_WORD - 1)) || rx_axis_tlast_i;
      push_word_c = word_new;
      ovf_c       = push_c && fifo_full && !pop_c && rstn_i;
      err_new     = err_base || sat_hit || ovf_c;

      if (push_c) begin
        word_d = '0;
        lane_d = '0;
      end else begin
        word_d = word_new;
        lane_d = lane_cur + lane_t'(1);
      end
      len_d = len_new;
      err_d = err_new;

      if (rx_axis_tlast_i) begin
        state_d = ST_WAIT_SOF;
        done_d  = 1'b1;
        flen_d  = len_new;
        ferr_d  = err_new || rx_axis_tuser_i;
      end else begin
        state_d = ST_RECV;
      end
    end
  end

  // State and status registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_WAIT_SOF;
      lane_q  <= '0;
      word_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      flen_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= done_d;
      flen_q  <= flen_d;
      ferr_q  <= ferr_d;
    end
  end

  eth_rx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_c),
    .data_i  (push_word_c),
    .pop_i   (pop_c),
    .data_o  (data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule
